mips_decode_exec: RTL and testbench
===================================

// Module: mips_decode_exec
// PURPOSE
//  Combined decode/execute slice of the single-cycle MIPS core: main control decoder,
//  ALU-control decoder and 32-bit ALU, plus immediate extension, ALU-B operand select
//  and a registered branch-taken flag. Sits between register file and data memory.
//  All outputs except branch_taken are combinational from the current instruction.
// PARAMETERS
//  none (fixed 32-bit datapath, 6-bit opcode/funct, 4-bit ALU control)
// PORTS
//  clk           in   1   clock; only branch_taken is sequential
//  rst           in   1   asynchronous, active-high reset
//  instr         in   32  current instruction; [31:26] opcode, [5:0] funct, [15:0] imm
//  op_a          in   32  ALU operand A (rs data or PC value, selected outside)
//  rt_data       in   32  register rt read data
//  reg_dst       out  1   1 = write rd, 0 = write rt
//  jump          out  1   unconditional jump
//  branch        out  1   conditional branch (beq)
//  mem_read      out  1   data memory read enable
//  mem_to_reg    out  1   1 = writeback from memory, 0 = from ALU
//  mem_write     out  1   data memory write enable
//  alu_src       out  1   1 = ALU B is sign-extended immediate, 0 = rt_data
//  reg_write     out  1   register file write enable
//  alu_op        out  3   main-decoder ALU class
//  alu_ctrl      out  4   decoded ALU operation
//  imm_ext       out  32  {{16{instr[15]}}, instr[15:0]}
//  alu_result    out  32  ALU result
//  zero          out  1   alu_result == 0
//  branch_taken  out  1   registered (branch & zero)
// BEHAVIOUR
//  Main decode (opcode -> flags; unlisted flags 0):
//   0x00 R-type: reg_dst, reg_write, alu_op=010
//   0x23 lw: alu_src, mem_read, mem_to_reg, reg_write, alu_op=000
//   0x2B sw: alu_src, mem_write, alu_op=000
//   0x04 beq: branch, alu_op=001
//   0x08 addi: alu_src, reg_write, alu_op=000
//   0x0C andi: alu_src, reg_write, alu_op=011; 0x0D ori: same, alu_op=100
//   0x0A slti: alu_src, reg_write, alu_op=101
//   0x02 j: jump, alu_op=000
//   any other opcode: all flags 0, alu_op=000 (acts as NOP, no write)
//  ALU control (alu_op zero-extended to 4 bits internally):
//   000 ADD(0010); 001 SUB(0110); 011 AND(0000); 100 OR(0001); 101 SLT(0111)
//   010 by funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x27 NOR(1100),
//       0x2A SLT; any other funct -> ADD; other alu_op codes -> ADD
//  ALU: B = alu_src ? imm_ext : rt_data
//   ADD/SUB modulo 2^32, no overflow detection or trap
//   AND/OR/NOR bitwise; SLT = signed compare, result 32'd1 or 32'd0
//   undefined alu_ctrl codes -> result 0; zero = (alu_result == 32'h0) for every op
//  Sequential: on rst high, branch_taken = 0 immediately (async); on posedge clk,
//   branch_taken <= branch & zero. One-cycle latency; reasserting rst mid-run clears it.
//  No internal state besides branch_taken; no handshake.
// TESTING
//  R add: instr=0x00221820 (add $3,$1,$2), op_a=5, rt_data=7 -> alu_ctrl=0010,
//   alu_result=12, reg_dst=1, reg_write=1, zero=0
//  R sub to zero / slt signed: funct 0x22, op_a=rt_data=9 -> result 0, zero=1;
//   funct 0x2A, op_a=0xFFFFFFFF, rt_data=1 -> result 1
//  lw/sw: opcode 0x23, imm=0xFFFC, op_a=0x100 -> result 0xFC, mem_read=1,
//   mem_to_reg=1, alu_src=1; opcode 0x2B -> mem_write=1, reg_write=0
//  beq: opcode 0x04, op_a=rt_data=0x55 -> zero=1, branch=1; branch_taken 0 before
//   clk edge, 1 after; op_a!=rt_data -> branch_taken 0 after edge
//  reset: branch_taken=1, assert rst between edges -> 0 without clock; illegal
//   opcode 0x3F -> all control flags 0
//  wrap: ADD 0xFFFFFFFF + 1 -> 0, zero=1; ori imm 0x8000 -> imm_ext 0xFFFF8000

Source files
------------

// File: rtl/mips_decode_exec_if.sv
// Signal bundle between the decode/execute slice and the surrounding core: instruction and
// operands in, control flags and ALU results out.
interface mips_decode_exec_if;
  logic [31:0] instr;
  logic [31:0] op_a;
  logic [31:0] rt_data;
  logic        reg_dst;
  logic        jump;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [2:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;

  modport master (
    output instr, op_a, rt_data,
    input  reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    input  alu_op, alu_ctrl, imm_ext, alu_result, zero, branch_taken
  );

  modport slave (
    input  instr, op_a, rt_data,
    output reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
    output alu_op, alu_ctrl, imm_ext, alu_result, zero, branch_taken
  );
endinterface

// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS decode/execute slice: main decoder, ALU-control decoder, 32-bit ALU,
// immediate extension and a registered branch-taken flag.
module mips_decode_exec (
  input logic              clk,
  input logic              rst,
  mips_decode_exec_if.slave bus
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] alu_b;
  logic        branch_taken_d, branch_taken_q;
  logic        unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:16];
  assign bus.imm_ext  = {{16{bus.instr[15]}}, bus.instr[15:0]};

  // Main decoder; unknown opcodes fall through as a write-free NOP.
  always_comb begin
    bus.reg_dst    = 1'b0;
    bus.jump       = 1'b0;
    bus.branch     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_op     = 3'b000;
    case (opcode)
      OpRType: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        bus.alu_op    = 3'b010;
      end
      OpLw: begin
        bus.alu_src    = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      OpSw: begin
        bus.alu_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      OpBeq: begin
        bus.branch = 1'b1;
        bus.alu_op = 3'b001;
      end
      OpAddi: begin
        bus.alu_src   = 1'b1;
        bus.reg_write = 1'b1;
      end
      OpAndi, OpOri, OpSlti: begin
        bus.alu_src   = 1'b1;
        bus.reg_write = 1'b1;
        bus.alu_op    = (opcode == OpAndi) ? 3'b011 :
                        (opcode == OpOri)  ? 3'b100 : 3'b101;
      end
      OpJ: bus.jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus.alu_ctrl = AluAdd;
    case (bus.alu_op)
      3'b001: bus.alu_ctrl = AluSub;
      3'b011: bus.alu_ctrl = AluAnd;
      3'b100: bus.alu_ctrl = AluOr;
      3'b101: bus.alu_ctrl = AluSlt;
      3'b010: begin
        case (funct)
          6'h22, 6'h23: bus.alu_ctrl = AluSub;
          6'h24:        bus.alu_ctrl = AluAnd;
          6'h25:        bus.alu_ctrl = AluOr;
          6'h27:        bus.alu_ctrl = AluNor;
          6'h2A:        bus.alu_ctrl = AluSlt;
          default:      bus.alu_ctrl = AluAdd;
        endcase
      end
      default: bus.alu_ctrl = AluAdd;
    endcase
  end

  assign alu_b = bus.alu_src ? bus.imm_ext : bus.rt_data;

  always_comb begin
    bus.alu_result = 32'h0;
    case (bus.alu_ctrl)
      AluAdd: bus.alu_result = bus.op_a + alu_b;
      AluSub: bus.alu_result = bus.op_a - alu_b;
      AluAnd: bus.alu_result = bus.op_a & alu_b;
      AluOr:  bus.alu_result = bus.op_a | alu_b;
      AluNor: bus.alu_result = ~(bus.op_a | alu_b);
      AluSlt: bus.alu_result = {31'h0, $signed(bus.op_a) < $signed(alu_b)};
      default: bus.alu_result = 32'h0;
    endcase
  end

  assign bus.zero       = (bus.alu_result == 32'h0);
  assign branch_taken_d = bus.branch & bus.zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken_q <= 1'b0;
    end else begin
      branch_taken_q <= branch_taken_d;
    end
  end

  assign bus.branch_taken = branch_taken_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboard bench for mips_decode_exec: expectations queued with each stimulus and
// compared once the outputs have settled or the clock edge has passed.
module tb_mips_decode_exec;

  localparam int FResult = 0;
  localparam int FZero   = 1;
  localparam int FFlags  = 2;
  localparam int FAluOp  = 3;
  localparam int FCtrl   = 4;
  localparam int FImm    = 5;
  localparam int FBt     = 6;

  typedef struct {
    string       tag;
    int          field;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  mips_decode_exec_if bus ();

  mips_decode_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int field);
    case (field)
      FResult: return bus.alu_result;
      FZero:   return {31'h0, bus.zero};
      FFlags:  return {24'h0, bus.reg_dst, bus.jump, bus.branch, bus.mem_read,
                       bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write};
      FAluOp:  return {29'h0, bus.alu_op};
      FCtrl:   return {28'h0, bus.alu_ctrl};
      FImm:    return bus.imm_ext;
      default: return {31'h0, bus.branch_taken};
    endcase
  endfunction

  task automatic push(input string tag, input int field, input logic [31:0] exp);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.exp   = exp;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    bus.instr   = instr;
    bus.op_a    = a;
    bus.rt_data = b;
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.field), e.exp);
    end
  endtask

  // Independent reference for R-type functs.
  function automatic logic [31:0] ref_r(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h27:        return ~(a | b);
      6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:      return a + b;
    endcase
  endfunction

  logic [5:0]  functs [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
  logic [5:0]  f;
  logic [31:0] ra, rb, rexp;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(32'h0, 32'h0, 32'h0);
    #2;
    push("reset_bt", FBt, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // R add
    drive(32'h0022_1820, 32'd5, 32'd7);
    push("add_res", FResult, 32'd12);
    push("add_ctrl", FCtrl, 32'h2);
    push("add_flags", FFlags, 32'h81);
    push("add_aluop", FAluOp, 32'h2);
    push("add_zero", FZero, 32'h0);
    #1 drain();

    drive(32'h0022_1822, 32'd9, 32'd9);
    push("sub_res", FResult, 32'h0);
    push("sub_zero", FZero, 32'h1);
    push("sub_ctrl", FCtrl, 32'h6);
    #1 drain();

    drive(32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
    push("slt_res", FResult, 32'd1);
    push("slt_ctrl", FCtrl, 32'h7);
    #1 drain();

    drive(32'h0022_1827, 32'hF0F0_F0F0, 32'h0F0F_00FF);
    push("nor_res", FResult, 32'h0000_0F00);
    push("nor_ctrl", FCtrl, 32'hC);
    #1 drain();

    drive(32'h0022_1800, 32'd3, 32'd4);
    push("badfunct_res", FResult, 32'd7);
    #1 drain();

    drive(32'h8C22_FFFC, 32'h100, 32'h1234);
    push("lw_res", FResult, 32'hFC);
    push("lw_flags", FFlags, 32'h1B);
    push("lw_imm", FImm, 32'hFFFF_FFFC);
    push("lw_aluop", FAluOp, 32'h0);
    #1 drain();

    drive(32'hAC22_FFFC, 32'h100, 32'h1234);
    push("sw_res", FResult, 32'hFC);
    push("sw_flags", FFlags, 32'h06);
    #1 drain();

    drive(32'h2022_0010, 32'd1, 32'd0);
    push("addi_res", FResult, 32'h11);
    push("addi_flags", FFlags, 32'h03);
    #1 drain();

    drive(32'h3022_00F0, 32'h0000_0FF0, 32'd0);
    push("andi_res", FResult, 32'hF0);
    push("andi_aluop", FAluOp, 32'h3);
    #1 drain();

    drive(32'h3422_8000, 32'h0000_00F0, 32'd0);
    push("ori_imm", FImm, 32'hFFFF_8000);
    push("ori_res", FResult, 32'hFFFF_80F0);
    push("ori_ctrl", FCtrl, 32'h1);
    push("ori_aluop", FAluOp, 32'h4);
    #1 drain();

    drive(32'h2822_0005, 32'hFFFF_FFF0, 32'd0);
    push("slti_res", FResult, 32'd1);
    push("slti_aluop", FAluOp, 32'h5);
    #1 drain();

    drive(32'h0800_0010, 32'd0, 32'd0);
    push("j_flags", FFlags, 32'h40);
    #1 drain();

    drive(32'hFC00_0000, 32'd1, 32'd2);
    push("illegal_flags", FFlags, 32'h0);
    push("illegal_aluop", FAluOp, 32'h0);
    #1 drain();

    drive(32'h0022_1820, 32'hFFFF_FFFF, 32'd1);
    push("wrap_res", FResult, 32'h0);
    push("wrap_zero", FZero, 32'h1);
    #1 drain();

    // beq taken: flag visible only after the edge
    @(negedge clk);
    drive(32'h1022_0004, 32'h55, 32'h55);
    push("beq_zero", FZero, 32'h1);
    push("beq_flags", FFlags, 32'h20);
    push("beq_bt_pre", FBt, 32'h0);
    #1 drain();
    push("beq_bt_post", FBt, 32'h1);
    @(posedge clk);
    #1 drain();

    // async reset between edges
    @(negedge clk);
    rst = 1'b1;
    push("rst_async_bt", FBt, 32'h0);
    #1 drain();
    rst = 1'b0;
    @(posedge clk);
    #1;
    push("beq_bt_again", FBt, 32'h1);
    drain();

    @(negedge clk);
    drive(32'h1022_0004, 32'h55, 32'h56);
    push("beq_nt_zero", FZero, 32'h0);
    #1 drain();
    push("beq_nt_bt", FBt, 32'h0);
    @(posedge clk);
    #1 drain();

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      f  = functs[$urandom_range(0, 8)];
      ra = $urandom();
      rb = (i % 4 == 0) ? ra : $urandom();
      rexp = ref_r(f, ra, rb);
      drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, f}, ra, rb);
      push("rand_res", FResult, rexp);
      push("rand_zero", FZero, {31'h0, rexp == 32'h0});
      #1 drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
